// File: rtl/vec_assembler_pkg.sv
// Shared constants and types for the vector assembler and its popcount neighbour (cnt1).
// Holds the word-count / popcount-width derivations, the last-word valid width,
// and the FIFO entry layout {last, cnt, vector} with its width.
package vec_assembler_pkg;

  // Derivations shared with cnt1 so both stages agree on framing and counter width.
  function automatic int sub_vector_no(input int vector_width, input int bus_width);
    return (vector_width + bus_width - 1) / bus_width;
  endfunction

  function automatic int cnt_width(input int vector_width);
    return $clog2(vector_width);
  endfunction

  localparam int VECTOR_WIDTH   = 920;
  localparam int BUS_WIDTH      = 128;
  localparam int SUB_VECTOR_NO  = sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
  localparam int CNT_WIDTH      = cnt_width(VECTOR_WIDTH);
  // Only the low bits of the final word carry vector data.
  localparam int LAST_WORD_BITS = VECTOR_WIDTH - (SUB_VECTOR_NO - 1) * BUS_WIDTH;
  // Must be a power of two and at least 2.
  localparam int FIFO_DEPTH     = 4;

  typedef struct packed {
    logic                    last;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [VECTOR_WIDTH-1:0] vec;
  } entry_t;

  localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

// File: rtl/vec_assembler_if.sv
// Handshake bundle between cnt1 (upstream words), the assembler and the similarity stage.
// Ports: up_* word stream with valid/ready plus CntNew/Cnt/Last framing;
// dn_* assembled vector, popcount and stream-last with valid/ready.
interface vec_assembler_if;
  import vec_assembler_pkg::*;

  logic [BUS_WIDTH-1:0]    up_SubVector;
  logic                    up_Valid;
  logic [CNT_WIDTH-1:0]    up_Cnt;
  logic                    up_CntNew;
  logic                    up_Last;
  logic                    up_Ready;

  logic [VECTOR_WIDTH-1:0] dn_Vector;
  logic [CNT_WIDTH-1:0]    dn_Cnt;
  logic                    dn_Last;
  logic                    dn_Valid;
  logic                    dn_Ready;

  // Assembler side.
  modport slave (
    input  up_SubVector, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    output up_Ready, dn_Vector, dn_Cnt, dn_Last, dn_Valid
  );

  // Environment side: drives words, consumes vectors.
  modport master (
    output up_SubVector, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    input  up_Ready, dn_Vector, dn_Cnt, dn_Last, dn_Valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous show-ahead FIFO; pop_dat always reflects the head entry.
// Ports: clk/rst, push/push_dat, pop/pop_dat, full/empty flags, level occupancy.
// Push while full and pop while empty are ignored. DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; consumers qualify pop_dat with ~empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/vec_assembler.sv
// Assembles SUB_VECTOR_NO bus words into one vector, pairs it with the upstream popcount
// and queues it for the similarity stage; flags framing mismatches against CntNew.
// Ports: clk, rst (async active-high), bus (slave side of vec_assembler_if), o_Err (sticky), o_Level.
module vec_assembler
  import vec_assembler_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  vec_assembler_if.slave         bus,
  output logic                   o_Err,
  output logic [$clog2(DEPTH):0] o_Level
);
  localparam int WCW   = $clog2(SUB_VECTOR_NO);
  localparam int ASM_W = (SUB_VECTOR_NO - 1) * BUS_WIDTH;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(SUB_VECTOR_NO - 1);

  logic [WCW-1:0]         word_cnt;
  logic [ASM_W-1:0]       asm_q;     // words 0..SUB_VECTOR_NO-2; the final word goes straight to the FIFO
  logic                   last_q;
  logic                   err_q;
  logic                   accept;
  logic                   at_last;
  logic                   close;
  logic                   do_push;
  logic                   full;
  logic                   empty;
  logic [ENTRY_WIDTH-1:0] pop_dat;
  entry_t                 push_entry;
  entry_t                 head_raw;
  entry_t                 head;

  // up_Ready comes from registered occupancy only, never from dn_Ready.
  assign bus.up_Ready = ~full;
  assign accept       = bus.up_Valid & ~full;
  assign at_last      = (word_cnt == LAST_IDX);
  // Either a proper end of vector or a framing error ends the current vector.
  assign close        = at_last | bus.up_CntNew;
  assign do_push      = accept & at_last & bus.up_CntNew;

  always_comb begin
    push_entry.vec  = {bus.up_SubVector[LAST_WORD_BITS-1:0], asm_q};
    push_entry.cnt  = bus.up_Cnt;
    push_entry.last = last_q | bus.up_Last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      asm_q    <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (close) begin
        word_cnt <= '0;
        last_q   <= 1'b0;
      end else begin
        word_cnt <= word_cnt + WCW'(1);
        last_q   <= last_q | bus.up_Last;
        for (int k = 0; k < SUB_VECTOR_NO - 1; k++) begin
          if (word_cnt == WCW'(k)) asm_q[k*BUS_WIDTH +: BUS_WIDTH] <= bus.up_SubVector;
        end
      end
      // CntNew early (a) or missing on the final word (b).
      if (bus.up_CntNew != at_last) err_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (do_push),
    .push_dat (push_entry),
    .pop      (bus.dn_Ready),
    .pop_dat  (pop_dat),
    .full     (full),
    .empty    (empty),
    .level    (o_Level)
  );

  // Zero the outputs while empty so stale storage never leaks out.
  assign head_raw      = pop_dat;
  assign head          = empty ? '0 : head_raw;
  assign bus.dn_Valid  = ~empty;
  assign bus.dn_Vector = head.vec;
  assign bus.dn_Cnt    = head.cnt;
  assign bus.dn_Last   = head.last;
  assign o_Err         = err_q;

endmodule

// File: tb/tb_vec_assembler.sv
module tb_vec_assembler;
  import vec_assembler_pkg::*;

  localparam int LIMIT = 50;

  logic clk = 1'b0;
  logic rst;
  logic o_Err;
  logic [$clog2(FIFO_DEPTH):0] o_Level;

  int checks = 0;
  int failures = 0;

  logic [BUS_WIDTH-1:0]    wv    [SUB_VECTOR_NO];
  logic [VECTOR_WIDTH-1:0] exp_v [5];
  logic [CNT_WIDTH-1:0]    exp_c [5];

  vec_assembler_if bus();

  vec_assembler dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_Err   (o_Err),
    .o_Level (o_Level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Directed word pattern; low 24 bits differ per seed and word index.
  task automatic fill(input int seed);
    for (int k = 0; k < SUB_VECTOR_NO; k++)
      wv[k] = {4{8'(seed), 8'(k), 16'(seed * 37 + k * 11)}};
  endtask

  // Reference vector: full words 0..6, low 24 bits of word 7.
  function automatic logic [VECTOR_WIDTH-1:0] wv_vec();
    logic [VECTOR_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < SUB_VECTOR_NO - 1; k++) v[k*BUS_WIDTH +: BUS_WIDTH] = wv[k];
    v[VECTOR_WIDTH-1 -: LAST_WORD_BITS] = wv[SUB_VECTOR_NO-1][LAST_WORD_BITS-1:0];
    return v;
  endfunction

  // Drives one word and returns #1 after the edge that accepted it.
  task automatic send_word(input logic [BUS_WIDTH-1:0] d, input logic cn,
                           input logic [CNT_WIDTH-1:0] c, input logic l);
    int waited;
    waited = 0;
    bus.up_SubVector = d;
    bus.up_Valid     = 1'b1;
    bus.up_CntNew    = cn;
    bus.up_Cnt       = c;
    bus.up_Last      = l;
    while (bus.up_Ready !== 1'b1 && waited < LIMIT) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited == LIMIT) begin
      checks++;
      failures++;
      $display("FAIL up_rdy_timeout observed=up_Ready low expected=high within %0d cycles", LIMIT);
    end
    @(posedge clk);
    #1;
    bus.up_Valid  = 1'b0;
    bus.up_CntNew = 1'b0;
    bus.up_Last   = 1'b0;
  endtask

  task automatic send_vec(input int first, input int n, input int cn_at,
                          input logic [CNT_WIDTH-1:0] c, input int last_at);
    for (int k = first; k < first + n; k++)
      send_word(wv[k], k == cn_at, c, k == last_at);
  endtask

  task automatic check_head(input string tag, input logic [VECTOR_WIDTH-1:0] ev,
                            input logic [CNT_WIDTH-1:0] ec, input logic el);
    check({tag, "_vld"}, bus.dn_Valid, 1'b1);
    for (int k = 0; k < SUB_VECTOR_NO - 1; k++)
      check($sformatf("%s_w%0d", tag, k), bus.dn_Vector[k*BUS_WIDTH +: BUS_WIDTH],
            ev[k*BUS_WIDTH +: BUS_WIDTH]);
    check({tag, "_w7"}, bus.dn_Vector[VECTOR_WIDTH-1 -: LAST_WORD_BITS],
          ev[VECTOR_WIDTH-1 -: LAST_WORD_BITS]);
    check({tag, "_cnt"}, bus.dn_Cnt, ec);
    check({tag, "_last"}, bus.dn_Last, el);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_vld"}, bus.dn_Valid, 1'b0);
    check({tag, "_vec"}, |bus.dn_Vector, 1'b0);
    check({tag, "_cnt"}, bus.dn_Cnt, '0);
    check({tag, "_last"}, bus.dn_Last, 1'b0);
    check({tag, "_lvl"}, o_Level, '0);
    check({tag, "_err"}, o_Err, 1'b0);
    check({tag, "_rdy"}, bus.up_Ready, 1'b1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.up_SubVector = '0;
    bus.up_Valid     = 1'b0;
    bus.up_Cnt       = '0;
    bus.up_CntNew    = 1'b0;
    bus.up_Last      = 1'b0;
    bus.dn_Ready     = 1'b0;
    tick(2);

    // Reset state
    check_cleared("rst");
    rst = 1'b0;
    tick(1);

    // Single vector: word k has its low k+1 bits set, popcount 1+2+..+8 = 36
    for (int k = 0; k < SUB_VECTOR_NO; k++) begin
      wv[k] = '0;
      for (int j = 0; j <= k; j++) wv[k][j] = 1'b1;
    end
    bus.dn_Ready = 1'b1;
    send_vec(0, 7, -1, '0, -1);
    check("t1_pre_vld", bus.dn_Valid, 1'b0);
    send_word(wv[7], 1'b1, 10'd36, 1'b0);
    check_head("t1", wv_vec(), 10'd36, 1'b0);
    check("t1_w7_bits", bus.dn_Vector[903:896], 8'hFF);
    check("t1_w2_bits", bus.dn_Vector[258:256], 3'b111);
    check("t1_err", o_Err, 1'b0);
    tick(1);
    check("t1_drain_vld", bus.dn_Valid, 1'b0);
    check("t1_drain_lvl", o_Level, '0);

    // Last-word masking: word 7 all ones, only 24 bits survive
    fill(2);
    wv[7] = '1;
    send_vec(0, 8, 7, 10'd500, -1);
    check("t2_top", bus.dn_Vector[919:896], 24'hFFFFFF);
    check_head("t2", wv_vec(), 10'd500, 1'b0);
    tick(1);

    // Backpressure: four vectors fill the FIFO, the fifth waits upstream
    bus.dn_Ready = 1'b0;
    for (int v = 0; v < 4; v++) begin
      fill(10 + v);
      exp_v[v] = wv_vec();
      exp_c[v] = 10'(v * 100 + 7);
      send_vec(0, 8, 7, exp_c[v], -1);
    end
    check("t3_lvl4", o_Level, 3'd4);
    check("t3_rdy0", bus.up_Ready, 1'b0);
    fill(14);
    exp_v[4] = wv_vec();
    exp_c[4] = 10'd919;
    bus.up_SubVector = wv[0];
    bus.up_Valid     = 1'b1;
    bus.up_Last      = 1'b1;
    tick(3);
    check("t3_hold_rdy", bus.up_Ready, 1'b0);
    check("t3_hold_lvl", o_Level, 3'd4);
    check_head("t3_hold", exp_v[0], exp_c[0], 1'b0);
    bus.dn_Ready = 1'b1;
    tick(1);
    bus.dn_Ready = 1'b0;
    check("t3_lvl3", o_Level, 3'd3);
    check("t3_rdy1", bus.up_Ready, 1'b1);
    send_vec(0, 8, 7, exp_c[4], 0);
    check("t3_lvl4b", o_Level, 3'd4);
    bus.dn_Ready = 1'b1;
    for (int v = 1; v < 5; v++) begin
      check_head($sformatf("t3_v%0d", v), exp_v[v], exp_c[v], v == 4);
      tick(1);
    end
    check("t3_empty_vld", bus.dn_Valid, 1'b0);
    check("t3_empty_lvl", o_Level, '0);

    // Simultaneous push and pop at level 2
    bus.dn_Ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      fill(20 + v);
      exp_v[v] = wv_vec();
      exp_c[v] = 10'(v + 40);
      if (v < 2) send_vec(0, 8, 7, exp_c[v], -1);
    end
    check("t4_lvl2_pre", o_Level, 3'd2);
    send_vec(0, 7, -1, '0, -1);
    bus.dn_Ready = 1'b1;
    send_word(wv[7], 1'b1, exp_c[2], 1'b0);
    bus.dn_Ready = 1'b0;
    check("t4_lvl2_post", o_Level, 3'd2);
    check_head("t4_headB", exp_v[1], exp_c[1], 1'b0);
    bus.dn_Ready = 1'b1;
    tick(1);
    check_head("t4_headC", exp_v[2], exp_c[2], 1'b0);
    tick(1);
    check("t4_empty_lvl", o_Level, '0);

    // Framing error (a): CntNew on word 3, then a clean vector
    fill(30);
    send_vec(0, 4, 3, 10'd99, -1);
    check("t5_err", o_Err, 1'b1);
    check("t5_vld", bus.dn_Valid, 1'b0);
    check("t5_lvl", o_Level, '0);
    fill(31);
    send_vec(0, 8, 7, 10'd123, -1);
    check_head("t5_good", wv_vec(), 10'd123, 1'b0);
    check("t5_err_sticky", o_Err, 1'b1);
    tick(1);

    // Reset clears the sticky error
    rst = 1'b1;
    #1;
    check("rst2_err", o_Err, 1'b0);
    rst = 1'b0;
    tick(1);

    // Framing error (b): CntNew missing on word 7
    bus.dn_Ready = 1'b0;
    fill(40);
    send_vec(0, 7, -1, '0, -1);
    check("t6_pre_err", o_Err, 1'b0);
    send_word(wv[7], 1'b0, 10'd5, 1'b0);
    check("t6_err", o_Err, 1'b1);
    check("t6_vld", bus.dn_Valid, 1'b0);
    check("t6_lvl", o_Level, '0);
    fill(41);
    send_vec(0, 8, 7, 10'd55, -1);
    check("t6_lvl1", o_Level, 3'd1);
    check_head("t6_good", wv_vec(), 10'd55, 1'b0);

    // Mid-vector reset after word 4; outputs clear without a clock edge
    fill(42);
    send_vec(0, 5, -1, '0, 1);
    rst = 1'b1;
    #1;
    check_cleared("t7_rst");
    rst = 1'b0;
    tick(1);

    // Fresh vector with up_Last only on word 2, then one without Last
    fill(43);
    send_vec(0, 8, 7, 10'd77, 2);
    check_head("t7", wv_vec(), 10'd77, 1'b1);
    check("t7_err", o_Err, 1'b0);
    bus.dn_Ready = 1'b1;
    tick(1);
    fill(44);
    send_vec(0, 8, 7, 10'd88, -1);
    check_head("t7_next", wv_vec(), 10'd88, 1'b0);
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_assembler.md
Name: vec_assembler

Overview:
- Sits directly downstream of the popcount stage (cnt1).
- Collects SUB_VECTOR_NO bus-wide sub-vectors into one VECTOR_WIDTH-bit vector and pairs it with its popcount, captured on the CntNew strobe.
- Buffers complete vectors in a small FIFO and presents them on a valid/ready interface to the similarity stage.
- Detects framing mismatches between its word counter and the upstream CntNew strobe.

Parameters:
- VECTOR_WIDTH, 920: bits in one full vector.
- BUS_WIDTH, 128: sub-vector width.
- SUB_VECTOR_NO, ceil(VECTOR_WIDTH/BUS_WIDTH) = 8: words per vector.
- CNT_WIDTH, $clog2(VECTOR_WIDTH) = 10: popcount width; matches upstream.
- DEPTH, 4: FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- up_SubVector  in  BUS_WIDTH  sub-vector word.
- up_Valid  in  1  word valid.
- up_Cnt  in  CNT_WIDTH  popcount; meaningful only when up_CntNew=1.
- up_CntNew  in  1  marks the last word of a vector; up_Cnt is final in that cycle.
- up_Last  in  1  marks a word of the last vector of a stream.
- up_Ready  out  1  block can accept a word.
- dn_Vector  out  VECTOR_WIDTH  assembled vector.
- dn_Cnt  out  CNT_WIDTH  popcount of dn_Vector.
- dn_Last  out  1  dn_Vector is the last vector of its stream.
- dn_Valid  out  1  FIFO head valid.
- dn_Ready  in  1  consumer accepts the head.
- o_Err  out  1  sticky framing error.
- o_Level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - Asynchronous assertion clears word counter, assembly register, sticky Last, FIFO pointers, level and o_Err.
  - After reset: dn_Valid=0, dn_Vector=0, dn_Cnt=0, dn_Last=0, o_Level=0, o_Err=0, up_Ready=1.
  - A partially assembled vector is discarded. Release is synchronised by the integrator.
- Transfers:
  - Upstream transfer = up_Valid & up_Ready.
  - Downstream transfer = dn_Valid & dn_Ready.
- up_Ready:
  - up_Ready = ~full, registered-state only; no combinational path from dn_Ready.
  - This stalls the cnt1 pipeline, whose shift enable is its dn_Ready.
- Assembly:
  - Word k (0-based) is written to bits [k*BUS_WIDTH +: BUS_WIDTH].
  - Word SUB_VECTOR_NO-1 contributes only its low VECTOR_WIDTH-(SUB_VECTOR_NO-1)*BUS_WIDTH bits (24 at defaults). Its upper bits are ignored.
- Sticky Last:
  - Set if up_Last=1 on any accepted word of the vector.
  - Cleared when the vector is pushed.
- Word counter:
  - 0..SUB_VECTOR_NO-1; increments per accepted word.
  - Wraps to 0 on a push or an error.
- Push:
  - On an accepted word with up_CntNew=1 and counter==SUB_VECTOR_NO-1.
  - Entry {assembled vector incl. this word, up_Cnt, sticky Last | up_Last} is written to the FIFO.
- Latency:
  - The last word is accepted at edge t; dn_Valid=1 with that entry in the cycle after t.
  - FIFO is show-ahead; outputs are read from the head entry.
- FIFO:
  - Simultaneous push and pop when not full: level unchanged.
  - When full: no push possible (up_Ready=0). A pop frees the slot from the next cycle.
  - Pop when empty: impossible (dn_Valid=0).
  - Pointers wrap modulo DEPTH.
  - dn_Vector, dn_Cnt and dn_Last hold stable while dn_Valid=1 and dn_Ready=0.
- Framing errors (both set o_Err and discard the partial vector, counter -> 0; no push):
  - (a) up_CntNew=1 on an accepted word with counter != SUB_VECTOR_NO-1.
  - (b) counter == SUB_VECTOR_NO-1 on an accepted word with up_CntNew=0.
  - o_Err stays set until rst.
- up_Cnt is taken verbatim; it is not recomputed or checked.

Decomposition:
- Shared package/include holds:
  - the SUB_VECTOR_NO and CNT_WIDTH derivation formulas, shared with cnt1;
  - the last-word valid-width constant;
  - the FIFO entry layout {last, cnt, vector}, plus its width constant.
- Sub-module: sync_fifo (WIDTH, DEPTH parameters; show-ahead; full/empty/level). It is reusable by the similarity stage.
- The assembler control and framing check stay in vec_assembler.

Test Plan:
- Single vector:
  - Stimulus: 8 words, word k = all-ones in low k+1 bits; up_CntNew on word 7 with up_Cnt=36; dn_Ready=1.
  - Response: one cycle after word 7, dn_Valid=1, dn_Cnt=36, dn_Vector bits [k*128 +: k+1] set, o_Err=0.
- Last-word masking:
  - Stimulus: word 7 = all-ones.
  - Response: dn_Vector[919:896]=all-ones; no bit above 919 exists; bits [895:0] follow words 0-6.
- Backpressure:
  - Stimulus: dn_Ready=0, stream 5 vectors.
  - Response: o_Level reaches 4 and up_Ready=0 after the 4th push; 5th vector held upstream.
  - Then raise dn_Ready for 1 cycle: up_Ready=1 on the next cycle, 5th vector completes.
  - All 5 vectors come out in order with correct counts.
- Simultaneous push/pop:
  - Stimulus: level 2; push and pop in the same cycle.
  - Response: level stays 2; head advances.
- Framing errors:
  - Stimulus: up_CntNew on word 3.
  - Response: o_Err=1, no push, next 8-word vector with correct CntNew is pushed normally.
  - Stimulus: missing CntNew on word 7.
  - Response: o_Err=1, no push.
- Mid-vector reset and stream Last:
  - Stimulus: assert rst after word 4.
  - Response: outputs clear immediately; a fresh 8-word vector with up_Last=1 only on word 2 emerges with dn_Last=1.
